vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Timing controller for the VGA output path: divides `clk` into a pixel-enable strobe and runs horizontal/vertical scan counters with per-axis phase FSMs.
- Drives `Hsync`/`Vsync` and presents pixel coordinates to the board renderer.
- Registers and blanks the returned colour onto `vgaRed`/`vgaGreen`/`vgaBlue`.
- Arbitrates board-state updates: game logic may write the board only inside a vertical-blanking grant window, so a frame never shows a half-updated board.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); must be >= 2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted level of `Hsync`/`Vsync` (0 = active-low).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- pix_en  out  1  one-clk strobe, once per CLK_DIV clks.
- hcount  out  10  current pixel column, 0..H_TOTAL-1.
- vcount  out  10  current line, 0..V_TOTAL-1.
- active  out  1  hcount < H_ACTIVE and vcount < V_ACTIVE.
- line_start  out  1  pulse on the pix_en where hcount becomes 0.
- frame_start  out  1  pulse on the pix_en where hcount=0 and vcount=0.
- rgb_in  in  8  {R[2:0],G[2:0],B[1:0]} for the current hcount/vcount; combinational from the renderer.
- vgaRed  out  3  registered red.
- vgaGreen  out  3  registered green.
- vgaBlue  out  2  registered blue (bits [2:1] at top level).
- Hsync  out  1  horizontal sync.
- Vsync  out  1  vertical sync.
- upd_req  in  1  game logic requests the board-write window.
- upd_gnt  out  1  board write permitted while high.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Reset values:
  - All outputs 0, except `Hsync`/`Vsync`, which reset to ~SYNC_POL.
  - Divider, hcount and vcount reset to 0.
  - Both FSMs reset to ACTIVE.
  - The first pix_en comes CLK_DIV clks after rst_n rises.
  - Reset mid-frame aborts immediately to these values on the next edge and drops upd_gnt.
- Divider: counts 0..CLK_DIV-1; pix_en=1 when the count equals CLK_DIV-1.
- Counters advance only on pix_en:
  - hcount wraps H_TOTAL-1 -> 0.
  - vcount increments only on the h wrap, and wraps V_TOTAL-1 -> 0.
- Per-axis FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each transition occurs on the pix_en where the counter crosses the boundaries H_ACTIVE, +H_FP, +H_SYNC, and the wrap.
  - The V FSM steps only on the h wrap.
- Sync outputs:
  - Hsync = SYNC_POL while the H FSM is in SYNC (hcount 656..751).
  - Vsync = SYNC_POL while the V FSM is in SYNC (vcount 490..491).
- Colour and sync alignment:
  - On pix_en the block registers rgb_in if active, else 8'h00.
  - Hsync and Vsync are registered on the same pix_en.
  - Colour and sync therefore lag hcount/vcount by exactly one pixel and are mutually aligned.
  - Outputs hold between pix_en strobes.
- line_start and frame_start are one clk wide, coincident with the pix_en that loads hcount=0.
- Grant arbitration:
  - The grant window is vcount >= V_ACTIVE (vblank).
  - upd_gnt rises on the clk after upd_req is high inside the window.
  - upd_gnt falls on the clk after upd_req drops.
  - upd_gnt is forced low on the pix_en where vcount wraps to 0 (window end), even if upd_req stays high.
  - After a forced drop, no re-grant occurs until the next window.
- Simultaneous events:
  - If upd_req rises in the same clk the window closes, no grant is issued.
  - If upd_req is held high continuously across frames, one grant is issued per window.

Decomposition:
- Shared package holds:
  - the timing constants and derived H_TOTAL/V_TOTAL;
  - the phase encoding ACTIVE=0, FRONT=1, SYNC=2, BACK=3;
  - the rgb field slices.
- One sub-module, `scan_axis`, is natural. It contains a counter plus a phase FSM, is parameterised by the four segment lengths, and has inputs `step` and outputs `count`, `phase` and `wrap`. It is instantiated twice: H steps on pix_en, V steps on the H wrap.

Test Plan:
1. Reset, then release: first pix_en after 4 clks; pix_en period 4 clks; hcount runs 0..799 then 0; line_start every 3200 clks.
2. Full frame: Hsync low exactly for registered hcount 656..751 (96 pixels); Vsync low for vcount 490..491; frame_start every 1,680,000 clks.
3. rgb_in=8'hFF constant: outputs 3'b111/3'b111/2'b11 for hcount 0..639 of lines 0..479, else 0. Colour edge lags the hcount=0 pix_en by one pixel.
4. upd_req pulsed at vcount=100: no grant. Held from vcount=100: upd_gnt rises 1 clk after vcount reaches 480, and drops at the pix_en where vcount wraps to 0.
5. upd_req raised at vcount=500, dropped at vcount=510: upd_gnt high from 501-ish (req+1 clk) until req+1 clk after the drop; no re-grant at vcount 511..524 unless req rises again.
6. rst_n low at hcount=300, vcount=200 for one clk: next edge all outputs at reset values, counters 0, upd_gnt 0; scan restarts cleanly.

Source files
------------

// File: rtl/vga_scan_ctrl_pkg.sv
// Shared VGA timing constants, scan phase encoding and rgb field helpers.
package vga_scan_ctrl_pkg;

    localparam int CNT_W        = 10;
    localparam int CLK_DIV_DEF  = 4;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // rgb_in packs {R[2:0], G[2:0], B[1:0]}
    function automatic logic [2:0] rgb_red(input logic [7:0] rgb);
        return rgb[7:5];
    endfunction

    function automatic logic [2:0] rgb_green(input logic [7:0] rgb);
        return rgb[4:2];
    endfunction

    function automatic logic [1:0] rgb_blue(input logic [7:0] rgb);
        return rgb[1:0];
    endfunction

endpackage

// File: rtl/vga_scan_ctrl_axis.sv
// One scan axis: wrapping position counter plus the ACTIVE/FRONT/SYNC/BACK phase FSM.
module scan_axis
    import vga_scan_ctrl_pkg::*;
#(
    parameter int ACT = 640,
    parameter int FP  = 16,
    parameter int SYN = 96,
    parameter int BP  = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACT + FP + SYN + BP;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACT - 1);
    localparam logic [CNT_W-1:0] FP_END  = CNT_W'(ACT + FP - 1);
    localparam logic [CNT_W-1:0] SYN_END = CNT_W'(ACT + FP + SYN - 1);

    phase_t phase_nxt;

    assign wrap = step && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            phase <= phase_nxt;
            if (step)
                count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

    // phase always tracks which segment the counter will hold after this step
    always_comb begin
        phase_nxt = phase;
        if (step) begin
            unique case (phase)
                PH_ACTIVE: if (count == ACT_END) phase_nxt = PH_FRONT;
                PH_FRONT:  if (count == FP_END)  phase_nxt = PH_SYNC;
                PH_SYNC:   if (count == SYN_END) phase_nxt = PH_BACK;
                PH_BACK:   if (count == LAST)    phase_nxt = PH_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan timing: pixel strobe, H/V scan axes, registered colour/sync, vblank board-write grant.
module vga_scan_ctrl
    import vga_scan_ctrl_pkg::*;
#(
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    input  logic [7:0]       rgb_in,
    output logic [2:0]       vgaRed,
    output logic [2:0]       vgaGreen,
    output logic [1:0]       vgaBlue,
    output logic             Hsync,
    output logic             Vsync,
    input  logic             upd_req,
    output logic             upd_gnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             h_wrap, v_wrap;
    phase_t           h_phase, v_phase;
    logic             active_now;
    logic             started;
    logic             window;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            div <= '0;
        else
            div <= tick ? '0 : div + DIV_W'(1);
    end

    scan_axis #(.ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP)) u_h (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (tick),
        .count (hcount),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    scan_axis #(.ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP)) u_v (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (h_wrap),
        .count (vcount),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    assign active_now = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    // counters sit at 0,0 during reset; active stays low until scanning starts
    assign active     = active_now && started;
    assign window     = (v_phase != PH_ACTIVE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            started     <= 1'b0;
            vgaRed      <= '0;
            vgaGreen    <= '0;
            vgaBlue     <= '0;
            Hsync       <= ~SYNC_POL;
            Vsync       <= ~SYNC_POL;
            upd_gnt     <= 1'b0;
        end else begin
            pix_en      <= tick;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            // window end forces the grant low; it cannot re-rise until vblank returns
            upd_gnt     <= upd_req && window && !v_wrap;
            if (tick) begin
                started  <= 1'b1;
                vgaRed   <= active_now ? rgb_red(rgb_in)   : 3'd0;
                vgaGreen <= active_now ? rgb_green(rgb_in) : 3'd0;
                vgaBlue  <= active_now ? rgb_blue(rgb_in)  : 2'd0;
                Hsync    <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                Vsync    <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a shrunken raster (15x10 pixels, CLK_DIV=4).
module tb_vga_scan_ctrl;

    localparam int CD = 4;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk, rst_n;
    logic       pix_en, active, line_start, frame_start;
    logic [9:0] hcount, vcount;
    logic [7:0] rgb_in;
    logic [2:0] vgaRed, vgaGreen;
    logic [1:0] vgaBlue;
    logic       Hsync, Vsync, upd_req, upd_gnt;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;
    int cur_h, cur_v;
    bit cur_pe;

    vga_scan_ctrl #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .active(active), .line_start(line_start), .frame_start(frame_start),
        .rgb_in(rgb_in), .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .Hsync(Hsync), .Vsync(Vsync), .upd_req(upd_req), .upd_gnt(upd_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int h, input int v);
        return 8'((h * 37 + v * 11 + 1) % 256);
    endfunction

    assign rgb_in = pat(int'(hcount), int'(vcount));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    task automatic chk_reset();
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_hcount", int'(hcount), 0);
        chk("rst_vcount", int'(vcount), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_line_start", int'(line_start), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_rgb", int'({vgaRed, vgaGreen, vgaBlue}), 0);
        chk("rst_hsync", int'(Hsync), 1);
        chk("rst_vsync", int'(Vsync), 1);
        chk("rst_gnt", int'(upd_gnt), 0);
    endtask

    // Advance one clk; expectations come from k = clks since reset release.
    task automatic tick_chk();
        int p, hc, vc, q, qh, qv;
        logic [7:0] col;
        bit pe, hs, vs;
        @(posedge clk);
        k++;
        @(negedge clk);
        p  = k / CD;
        pe = (k > 0) && (k % CD == 0);
        hc = p % HT;
        vc = (p / HT) % VT;
        col = 8'h00;
        hs = 1'b1;
        vs = 1'b1;
        if (p > 0) begin
            q  = p - 1;
            qh = q % HT;
            qv = (q / HT) % VT;
            if (qh < HA && qv < VA) col = pat(qh, qv);
            hs = !(qh >= HA + HF && qh < HA + HF + HS);
            vs = !(qv >= VA + VF && qv < VA + VF + VS);
        end
        cur_h = hc; cur_v = vc; cur_pe = pe;
        chk("pix_en", int'(pix_en), int'(pe));
        chk("hcount", int'(hcount), hc);
        chk("vcount", int'(vcount), vc);
        chk("active", int'(active), int'(p > 0 && hc < HA && vc < VA));
        chk("line_start", int'(line_start), int'(pe && hc == 0));
        chk("frame_start", int'(frame_start), int'(pe && hc == 0 && vc == 0));
        chk("red", int'(vgaRed), int'(col[7:5]));
        chk("green", int'(vgaGreen), int'(col[4:2]));
        chk("blue", int'(vgaBlue), int'(col[1:0]));
        chk("hsync", int'(Hsync), int'(hs));
        chk("vsync", int'(Vsync), int'(vs));
    endtask

    // Stop on the strobe cycle where the scan reaches (h, v).
    task automatic run_until(input int h, input int v);
        for (int i = 0; i < 4000; i++) begin
            tick_chk();
            if (cur_pe && cur_h == h && cur_v == v) return;
        end
        chk("run_until_timeout", 0, 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        upd_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        k = 0;

        // full frame of timing, colour and sync
        run_until(0, 0);

        // short request outside vblank
        run_until(0, 1);
        upd_req = 1'b1;
        tick_chk();
        upd_req = 1'b0;
        chk("gnt_pulse", int'(upd_gnt), 0);

        // held request: grant in vblank, forced off at wrap, one grant per window
        upd_req = 1'b1;
        run_until(0, 4);
        chk("gnt_early", int'(upd_gnt), 0);
        tick_chk();
        chk("gnt_rise", int'(upd_gnt), 1);
        run_until(14, 9);
        chk("gnt_hold", int'(upd_gnt), 1);
        run_until(0, 0);
        chk("gnt_forced", int'(upd_gnt), 0);
        repeat (8) tick_chk();
        chk("gnt_locked", int'(upd_gnt), 0);
        run_until(0, 4);
        tick_chk();
        chk("gnt_regrant", int'(upd_gnt), 1);
        upd_req = 1'b0;
        tick_chk();
        chk("gnt_fall", int'(upd_gnt), 0);

        // request raised and dropped inside the window
        run_until(0, 5);
        upd_req = 1'b1;
        tick_chk();
        chk("gnt_mid", int'(upd_gnt), 1);
        run_until(0, 7);
        chk("gnt_mid_hold", int'(upd_gnt), 1);
        upd_req = 1'b0;
        tick_chk();
        chk("gnt_drop", int'(upd_gnt), 0);
        run_until(0, 9);
        chk("gnt_none", int'(upd_gnt), 0);

        // request rises on the clk the window closes
        run_until(14, 9);
        repeat (3) tick_chk();
        upd_req = 1'b1;
        tick_chk();
        chk("gnt_simul", int'(upd_gnt), 0);
        tick_chk();
        chk("gnt_simul2", int'(upd_gnt), 0);
        upd_req = 1'b0;

        // mid-frame reset with grant held
        run_until(0, 5);
        upd_req = 1'b1;
        tick_chk();
        chk("gnt_pre_rst", int'(upd_gnt), 1);
        run_until(3, 6);
        tick_chk();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst_n   = 1'b1;
        upd_req = 1'b0;
        k = 0;
        run_until(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
